// File: rtl/kadai10_4_2_pkg.sv
// kadai10_4_2_pkg
// Shared definitions for the kadai10_4_2 word multiplexer:
//   DEFAULT_WIDTH     - default data word width
//   sel_t             - 2-bit select type
//   SEL_A .. SEL_D    - select encodings for inputs a, b, c, d
package kadai10_4_2_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

endpackage : kadai10_4_2_pkg

// File: rtl/kadai10_4_2_mux_mux4_comb.sv
// mux4_comb
// Purely combinational 4:1 word selector.
// Ports:
//   s          in   2      select (SEL_A..SEL_D)
//   a, b, c, d in   WIDTH  data inputs 0..3
//   z          out  WIDTH  selected word
module mux4_comb
  import kadai10_4_2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] z
);

  // Select one of the four words; an unknown select propagates as all-X
  // in simulation and is a don't-care for synthesis.
  always_comb begin
    z = {WIDTH{1'b0}};
    case (s)
      SEL_A:   z = a;
      SEL_B:   z = b;
      SEL_C:   z = c;
      SEL_D:   z = d;
      default: z = {WIDTH{1'bx}};
    endcase
  end

endmodule : mux4_comb

// File: rtl/kadai10_4_2_mux.sv
// kadai10_4_2_mux
// Four-input word multiplexer with a combinational output and a
// one-cycle registered copy (plus the registered select).
// Optional feature macro: KADAI10_4_2_PARITY_EN adds zp_q, the even
// parity (XOR-reduction) of the word captured into z_q.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   s          in   2      select: 00 a, 01 b, 10 c, 11 d
//   a, b, c, d in   WIDTH  data inputs
//   z          out  WIDTH  combinational selected word (unaffected by rst)
//   z_q        out  WIDTH  registered z
//   s_q        out  2      registered s, aligned with z_q
//   zp_q       out  1      parity of z_q (only with KADAI10_4_2_PARITY_EN)
module kadai10_4_2_mux
  import kadai10_4_2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_q,
  output logic [1:0]       s_q
`ifdef KADAI10_4_2_PARITY_EN
  ,
  output logic             zp_q
`endif
);

  logic [WIDTH-1:0] z_s;
  logic [WIDTH-1:0] z_q_r;
  sel_t             s_q_r;

  mux4_comb #(
    .WIDTH (WIDTH)
  ) u_mux4_comb (
    .s (s),
    .a (a),
    .b (b),
    .c (c),
    .d (d),
    .z (z_s)
  );

  assign z   = z_s;
  assign z_q = z_q_r;
  assign s_q = s_q_r;

  // Output registers: load the selected word and its select every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q_r <= {WIDTH{1'b0}};
      s_q_r <= SEL_A;
    end else begin
      z_q_r <= z_s;
      s_q_r <= s;
    end
  end

`ifdef KADAI10_4_2_PARITY_EN
  logic zp_q_r;

  // Even-parity bit of a word: 1 when the word has an odd number of ones.
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Parity register, captured from the same word that z_q captures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zp_q_r <= 1'b0;
    end else begin
      zp_q_r <= even_parity(z_s);
    end
  end

  assign zp_q = zp_q_r;
`endif

endmodule : kadai10_4_2_mux

// File: tb/tb_kadai10_4_2_mux.sv
// tb_kadai10_4_2_mux
// Directed self-checking bench for kadai10_4_2_mux (WIDTH = 8).
module tb_kadai10_4_2_mux;

  logic       clk;
  logic       rst;
  logic [1:0] s;
  logic [7:0] a, b, c, d;
  logic [7:0] z, z_q;
  logic [1:0] s_q;
`ifdef KADAI10_4_2_PARITY_EN
  logic       zp_q;
`endif

  int checks = 0;
  int fails  = 0;

  kadai10_4_2_mux #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .s   (s),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .z   (z),
    .z_q (z_q),
    .s_q (s_q)
`ifdef KADAI10_4_2_PARITY_EN
    ,
    .zp_q (zp_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hand-computed word for each select with a=00 b=0F c=F0 d=FF.
  function automatic logic [7:0] exp_word(input logic [1:0] sel);
    case (sel)
      2'b00:   return 8'h00;
      2'b01:   return 8'h0F;
      2'b10:   return 8'hF0;
      default: return 8'hFF;
    endcase
  endfunction

  logic [1:0] seq [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00, 2'b10};

  initial begin
    rst = 1'b1;
    s   = 2'b00;
    a   = 8'h00;
    b   = 8'h0F;
    c   = 8'hF0;
    d   = 8'hFF;

    // Combinational stepping, held in reset: z follows s, registers stay 0.
    #1;
    check("reset_z_q", z_q, 8'h00);
    check("reset_s_q", {6'd0, s_q}, 8'h00);
    check("comb_s00", z, 8'h00);
    #10 s = 2'b01; #1 check("comb_s01", z, 8'h0F);
    #10 s = 2'b10; #1 check("comb_s10", z, 8'hF0);
    #10 s = 2'b11; #1 check("comb_s11", z, 8'hFF);
    check("reset_hold_z_q", z_q, 8'h00);

    // Release reset and step s every cycle: one-cycle lag on z_q and s_q.
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) s = seq[i];
      #1;
      check("lag_z", z, exp_word(seq[i]));
      if (i > 0) check("lag_hold_z_q", z_q, exp_word(seq[i-1]));
      @(posedge clk) #1;
      check("lag_z_q", z_q, exp_word(seq[i]));
      check("lag_s_q", {6'd0, s_q}, {6'd0, seq[i]});
    end

    // Asynchronous reset between edges while z_q = FF.
    @(negedge clk) s = 2'b11;
    @(posedge clk) #1;
    check("pre_rst_z_q", z_q, 8'hFF);
    #2 rst = 1'b1;
    #1;
    check("async_rst_z_q", z_q, 8'h00);
    check("async_rst_s_q", {6'd0, s_q}, 8'h00);
    check("async_rst_z", z, 8'hFF);
    @(posedge clk) #1;
    check("rst_edge_z_q", z_q, 8'h00);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    check("post_rst_z_q", z_q, 8'hFF);
    check("post_rst_s_q", {6'd0, s_q}, 8'h03);

    // Hold s=01 and change b: z follows at once, z_q at the next edge.
    @(negedge clk) s = 2'b01;
    @(posedge clk) #1;
    check("b_old_z_q", z_q, 8'h0F);
    @(negedge clk) b = 8'h3C;
    #1;
    check("b_new_z", z, 8'h3C);
    check("b_hold_z_q", z_q, 8'h0F);
    @(posedge clk) #1;
    check("b_new_z_q", z_q, 8'h3C);

`ifdef KADAI10_4_2_PARITY_EN
    // Parity follows the captured word one cycle after its select.
    @(negedge clk) begin b = 8'h0F; s = 2'b01; end
    @(posedge clk) #1;
    check("par_b", {7'd0, zp_q}, 8'h00);
    @(negedge clk) begin c = 8'hF1; s = 2'b10; end
    @(posedge clk) #1;
    check("par_c", {7'd0, zp_q}, 8'h01);
    check("par_c_word", z_q, 8'hF1);
    #2 rst = 1'b1;
    #1;
    check("par_rst", {7'd0, zp_q}, 8'h00);
    @(negedge clk) rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule : tb_kadai10_4_2_mux
